// File: rtl/bitcoin_nonce_dispatch.sv
// Sweeps nonces through one simplified_sha256 worker: phase 2 on the header tail, then
// phase 3 on the phase-2 digest, writing word 0 of each final digest to memory.
module bitcoin_nonce_dispatch #(
    parameter int unsigned NUM_NONCES = 16,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       midstate [8],
    input  logic [31:0]       msg_tail [3],
    input  logic [ADDR_W-1:0] output_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              w_start,
    output logic              w_phase_sel,
    output logic [3:0]        w_nonce,
    output logic [31:0]       w_hi [8],
    output logic [31:0]       w_msg_tail [3],
    input  logic [31:0]       w_ho [8],
    input  logic              w_finish
);

    typedef enum logic [2:0] {
        StIdle,
        StP2Go,
        StP2Wait,
        StP3Go,
        StP3Wait,
        StWrite,
        StFin
    } state_e;

    state_e              state_q, state_d;
    logic [4:0]          nonce_q;
    logic [31:0]         mid_q  [8];
    logic [31:0]         tail_q [3];
    logic [31:0]         dig2_q [8];
    logic [31:0]         res_q;
    logic [ADDR_W-1:0]   base_q;

    logic latch_en, cap2_en, cap3_en, nonce_inc, last_nonce;

    assign last_nonce = (nonce_q == 5'(NUM_NONCES - 1));

    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        cap2_en   = 1'b0;
        cap3_en   = 1'b0;
        nonce_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    latch_en = 1'b1;
                    state_d  = StP2Go;
                end
            end
            StP2Go: state_d = StP2Wait;
            StP2Wait: begin
                if (w_finish) begin
                    cap2_en = 1'b1;
                    state_d = StP3Go;
                end
            end
            StP3Go: state_d = StP3Wait;
            StP3Wait: begin
                if (w_finish) begin
                    cap3_en = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (last_nonce) begin
                    state_d = StFin;
                end else begin
                    nonce_inc = 1'b1;
                    state_d   = StP2Go;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            nonce_q <= '0;
            res_q   <= '0;
            base_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                mid_q[i]  <= '0;
                dig2_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                tail_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                nonce_q <= '0;
                base_q  <= output_addr;
                mid_q   <= midstate;
                tail_q  <= msg_tail;
            end
            if (nonce_inc) begin
                nonce_q <= nonce_q + 5'd1;
            end
            if (cap2_en) begin
                dig2_q <= w_ho;
            end
            if (cap3_en) begin
                res_q <= w_ho[0];
            end
        end
    end

    // Worker-facing signals decode from state so they stay put across each *_WAIT.
    always_comb begin
        busy           = (state_q != StIdle);
        done           = (state_q == StFin);
        mem_we         = (state_q == StWrite);
        mem_addr       = mem_we ? (base_q + ADDR_W'(nonce_q)) : '0;
        mem_write_data = mem_we ? res_q : '0;
        w_start        = (state_q == StP2Go) || (state_q == StP3Go);
        w_phase_sel    = (state_q == StP3Go) || (state_q == StP3Wait);
        w_nonce        = nonce_q[3:0];
        w_msg_tail     = tail_q;
        for (int i = 0; i < 8; i++) begin
            w_hi[i] = w_phase_sel ? dig2_q[i] : mid_q[i];
        end
    end

endmodule
